count_direction_decoder: RTL and testbench

Receive-side companion to the 2-bit up/down counter: samples the counter's 2-bit output every enabled cycle, decodes each transition into up/down/hold steps, and maintains a signed position accumulator, a wrap indicator and illegal-transition error tracking. It sits downstream of the counter, on the same clock domain, and feeds status/display logic that needs motion direction and net count rather than the raw 2-bit value.

---
 rtl/count_direction_decoder.sv | 86 ++++++++
 tb/tb_count_direction_decoder.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/count_direction_decoder.sv
// count_direction_decoder: decodes successive 2-bit up/down counter samples into
// step pulses, a signed position accumulator, wrap detection and illegal-jump tracking.
module count_direction_decoder #(
    parameter int POS_W = 8,
    parameter int ERR_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample_en,
    input  logic [1:0]       data_in,
    output logic             step_up,
    output logic             step_down,
    output logic             dir_up,
    output logic             wrap,
    output logic [POS_W-1:0] position,
    output logic             error,
    output logic [ERR_W-1:0] err_count,
    output logic             locked
);
    typedef enum logic [1:0] {IDLE, TRACK, RESYNC} state_t;

    state_t           state, state_n;
    logic [1:0]       prev, prev_n, delta;
    logic             up_n, down_n, wrap_n, err_n, dir_n;
    logic [POS_W-1:0] pos_n;
    logic [ERR_W-1:0] cnt_n, cnt_inc;

    assign delta   = data_in - prev;
    assign cnt_inc = (err_count == '1) ? err_count : err_count + ERR_W'(1);
    assign locked  = (state == TRACK);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            prev      <= '0;
            step_up   <= 1'b0;
            step_down <= 1'b0;
            wrap      <= 1'b0;
            error     <= 1'b0;
            dir_up    <= 1'b0;
            position  <= '0;
            err_count <= '0;
        end else begin
            state     <= state_n;
            prev      <= prev_n;
            step_up   <= up_n;
            step_down <= down_n;
            wrap      <= wrap_n;
            error     <= err_n;
            dir_up    <= dir_n;
            position  <= pos_n;
            err_count <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        prev_n  = prev;
        up_n    = 1'b0;
        down_n  = 1'b0;
        wrap_n  = 1'b0;
        err_n   = 1'b0;
        dir_n   = dir_up;
        pos_n   = position;
        cnt_n   = err_count;
        if (sample_en) begin
            prev_n = data_in;
            // A +/-2 jump is ambiguous in direction, so it is flagged rather than counted
            err_n  = (state != IDLE) && (delta == 2'd2);
            cnt_n  = err_n ? cnt_inc : err_count;
            case (state)
                IDLE:    state_n = TRACK;
                TRACK: begin
                    up_n    = (delta == 2'd1);
                    down_n  = (delta == 2'd3);
                    wrap_n  = (up_n && prev == 2'd3) || (down_n && prev == 2'd0);
                    dir_n   = up_n ? 1'b1 : down_n ? 1'b0 : dir_up;
                    pos_n   = up_n ? position + POS_W'(1) : down_n ? position - POS_W'(1) : position;
                    state_n = err_n ? RESYNC : TRACK;
                end
                RESYNC:  state_n = err_n ? RESYNC : TRACK;
                default: state_n = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_count_direction_decoder.sv
// tb_count_direction_decoder: directed stimulus with a scoreboard queue of expected outputs.
module tb_count_direction_decoder;
    localparam int POS_W = 4;
    localparam int ERR_W = 4;

    typedef struct packed {
        logic             up, dn, dir, wr, err, lk;
        logic [POS_W-1:0] pos;
        logic [ERR_W-1:0] cnt;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             sample_en;
    logic [1:0]       data_in;
    logic             step_up, step_down, dir_up, wrap, error, locked;
    logic [POS_W-1:0] position;
    logic [ERR_W-1:0] err_count;

    int checks = 0;
    int errors = 0;
    exp_t q[$];

    int               m_state;
    logic [1:0]       m_prev;
    logic             m_dir;
    logic [POS_W-1:0] m_pos;
    logic [ERR_W-1:0] m_cnt;

    count_direction_decoder #(.POS_W(POS_W), .ERR_W(ERR_W)) dut (
        .clk(clk), .reset(reset), .sample_en(sample_en), .data_in(data_in),
        .step_up(step_up), .step_down(step_down), .dir_up(dir_up), .wrap(wrap),
        .position(position), .error(error), .err_count(err_count), .locked(locked)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_t e;
        m_state = 0; m_prev = 2'd0; m_dir = 1'b0; m_pos = '0; m_cnt = '0;
        e = '0;
        q.push_back(e);
    endtask

    task automatic model(input logic en, input logic [1:0] v);
        exp_t e;
        logic [1:0] d;
        e = '0;
        if (en) begin
            d = (v - m_prev) & 2'd3;
            if (m_state == 0) m_state = 1;
            else if (d == 2'd2) begin
                e.err = 1'b1;
                if (m_cnt != 4'hf) m_cnt = m_cnt + 4'd1;
                m_state = 2;
            end else if (m_state == 2) m_state = 1;
            else if (d == 2'd1) begin
                e.up = 1'b1; m_dir = 1'b1; m_pos = m_pos + 4'd1; e.wr = (m_prev == 2'd3);
            end else if (d == 2'd3) begin
                e.dn = 1'b1; m_dir = 1'b0; m_pos = m_pos - 4'd1; e.wr = (m_prev == 2'd0);
            end
            m_prev = v;
        end
        e.dir = m_dir; e.pos = m_pos; e.cnt = m_cnt; e.lk = (m_state == 1);
        q.push_back(e);
    endtask

    task automatic compare(input string tag);
        exp_t e;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $error("FAIL %s scoreboard empty", tag);
        end else begin
            e = q.pop_front();
            checks--;
            chk({tag, ".pulses"}, {3'b0, step_up, step_down, wrap, error, 1'b0}, {3'b0, e.up, e.dn, e.wr, e.err, 1'b0});
            chk({tag, ".levels"}, {6'b0, dir_up, locked}, {6'b0, e.dir, e.lk});
            chk({tag, ".pos"}, {4'b0, position}, {4'b0, e.pos});
            chk({tag, ".cnt"}, {4'b0, err_count}, {4'b0, e.cnt});
        end
    endtask

    task automatic sample(input logic en, input logic [1:0] v, input string tag);
        sample_en = en;
        data_in   = v;
        model(en, v);
        @(posedge clk);
        #1;
        compare(tag);
        sample_en = 1'b0;
    endtask

    task automatic sync_reset_start();
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        compare("reset");
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; sample_en = 1'b0; data_in = 2'd0;
        model_reset();
        @(posedge clk);
        #1;
        compare("reset_state");
        reset = 1'b0;

        sample(1'b1, 2'd0, "t1_ref");
        chk("t1_ref_nostep", {6'b0, step_up, step_down}, 8'd0);
        sample(1'b1, 2'd1, "t1_up1");
        sample(1'b1, 2'd2, "t1_up2");
        sample(1'b1, 2'd3, "t1_up3");
        sample(1'b1, 2'd0, "t1_up4");
        chk("t1_pos4_wrap", {3'b0, position, wrap}, {3'b0, 4'd4, 1'b1});

        sample(1'b1, 2'd1, "t2_up");
        sample(1'b1, 2'd0, "t2_dn1");
        chk("t2_dir_after_down", {7'b0, dir_up}, 8'd0);
        sample(1'b1, 2'd3, "t2_dn2_wrap");
        chk("t2_wrap_0_3", {7'b0, wrap}, 8'd1);
        sample(1'b1, 2'd2, "t2_dn3");
        sample(1'b1, 2'd1, "t2_dn4");
        sample(1'b1, 2'd0, "t2_dn5");
        chk("t2_pos0", {4'b0, position}, 8'd0);

        sample(1'b1, 2'd0, "t3_hold");
        sample(1'b1, 2'd2, "t3_err");
        chk("t3_err_unlock", {5'b0, error, locked, err_count[0]}, 8'b101);
        sample(1'b1, 2'd2, "t3_reref");
        chk("t3_relock_nostep", {6'b0, locked, step_up}, 8'b10);
        sample(1'b1, 2'd3, "t3_up");
        chk("t3_pos1", {4'b0, position}, 8'd1);

        sync_reset_start();
        sample(1'b1, 2'd0, "t4_ref");
        for (int i = 1; i <= 8; i++) sample(1'b1, 2'(i), "t4_up");
        chk("t4_pos_minus8", {4'b0, position}, 8'h08);

        sync_reset_start();
        sample(1'b1, 2'd0, "t4b_ref");
        for (int i = 1; i <= 9; i++) begin
            sample(1'b1, 2'(-i), "t4b_dn");
            if (i == 8) chk("t4b_pos_minus8", {4'b0, position}, 8'h08);
        end
        chk("t4b_pos_plus7", {4'b0, position}, 8'h07);

        sync_reset_start();
        sample(1'b1, 2'd0, "t5_ref");
        for (int i = 0; i < 17; i++) sample(1'b1, (i % 2 == 0) ? 2'd2 : 2'd0, "t5_err");
        chk("t5_sat_pulse", {3'b0, error, err_count}, {3'b0, 1'b1, 4'hf});

        sync_reset_start();
        sample(1'b1, 2'd0, "t6_ref");
        sample(1'b1, 2'd1, "t6_up1");
        sample(1'b1, 2'd2, "t6_up2");
        sample(1'b1, 2'd3, "t6_up3");
        chk("t6_pos3", {4'b0, position}, 8'd3);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        compare("t6_async_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) sample(1'b0, 2'd3, "t6_idle_en_low");
        sample(1'b1, 2'd1, "t6_reref");
        chk("t6_reref_nostep", {5'b0, step_up, step_down, locked}, 8'b001);
        sample(1'b1, 2'd2, "t6_up_after");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule
